// File: rtl/if_prefetch.sv
// Instruction-fetch front end: assembles little-endian 32-bit words from a
// narrow memory port and buffers them in a first-word-fallthrough queue.
module if_prefetch #(
  parameter int          MEM_W    = 8,
  parameter int          IQ_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             branch_flag_i,
  input  logic [31:0]      branch_addr_i,
  output logic             mem_ce_o,
  output logic [31:0]      mem_addr_o,
  input  logic             mem_ready_i,
  input  logic [MEM_W-1:0] mem_rdata_i,
  output logic             if_valid_o,
  output logic [31:0]      if_inst_o,
  output logic [31:0]      if_pc_o
);

  localparam int BEATS  = 32 / MEM_W;
  localparam int PTR_W  = $clog2(IQ_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [31:0]       STEP      = 32'(MEM_W / 8);
  localparam logic [CNT_W-1:0]  DEPTH     = CNT_W'(IQ_DEPTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic {FETCH, WAIT} state_t;

  state_t            state_reg;
  logic              mem_ce_reg;
  logic [31:0]       mem_addr_reg;
  logic [BEAT_W-1:0] beat_reg;
  logic [31:0]       asm_reg;
  logic [31:0]       asm_pc_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [CNT_W-1:0]  count_reg;

  logic [31:0] q_inst [IQ_DEPTH];
  logic [31:0] q_pc   [IQ_DEPTH];

  logic        accept;
  logic        last;
  logic        push;
  logic        pop;
  logic [31:0] push_word;
  logic [31:0] push_pc;
  logic        branch_addr_unused;

  assign branch_addr_unused = ^branch_addr_i[1:0];

  assign accept     = mem_ce_reg && mem_ready_i;
  assign last       = accept && (beat_reg == LAST_BEAT);
  assign push       = last && !branch_flag_i;
  assign if_valid_o = (count_reg != '0);
  assign pop        = if_valid_o && !stall_i;

  // The final beat is merged combinationally so the word is pushed on the
  // same edge that accepts it.
  always_comb begin
    push_word = asm_reg;
    push_word[(BEATS-1)*MEM_W +: MEM_W] = mem_rdata_i;
    push_pc = (beat_reg == '0) ? mem_addr_reg : asm_pc_reg;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[wr_ptr_reg] <= push_word;
      q_pc[wr_ptr_reg]   <= push_pc;
    end
  end

  assign if_inst_o  = if_valid_o ? q_inst[rd_ptr_reg] : 32'h0;
  assign if_pc_o    = if_valid_o ? q_pc[rd_ptr_reg]   : 32'h0;
  assign mem_ce_o   = mem_ce_reg;
  assign mem_addr_o = mem_addr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= FETCH;
      mem_ce_reg   <= 1'b0;
      mem_addr_reg <= RESET_PC;
      beat_reg     <= '0;
      asm_reg      <= '0;
      asm_pc_reg   <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else if (branch_flag_i) begin
      // Redirect flushes the queue and any partial word.
      state_reg    <= FETCH;
      mem_ce_reg   <= 1'b1;
      mem_addr_reg <= {branch_addr_i[31:2], 2'b00};
      beat_reg     <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase

      case (state_reg)
        FETCH: begin
          if (!mem_ce_reg) begin
            mem_ce_reg <= 1'b1;
          end else if (accept) begin
            mem_addr_reg <= mem_addr_reg + STEP;
            asm_reg[beat_reg*MEM_W +: MEM_W] <= mem_rdata_i;
            if (beat_reg == '0) asm_pc_reg <= mem_addr_reg;
            if (beat_reg == LAST_BEAT) begin
              beat_reg <= '0;
              // Only start another word if a slot will be free for it.
              if (!(((count_reg + CNT_W'(1)) < DEPTH) || pop)) begin
                state_reg  <= WAIT;
                mem_ce_reg <= 1'b0;
              end
            end else begin
              beat_reg <= beat_reg + 1'b1;
            end
          end
        end
        WAIT: begin
          if ((count_reg < DEPTH) || pop) begin
            state_reg  <= FETCH;
            mem_ce_reg <= 1'b1;
          end
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: 8-, 16- and 32-bit port instances sharing
// one byte-addressed memory model.
module tb_if_prefetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  localparam logic [31:0] W0   = 32'h00100513;
  localparam logic [31:0] W1   = 32'h00200593;
  localparam logic [31:0] W2   = 32'h00300613;
  localparam logic [31:0] W3   = 32'h00400693;
  localparam logic [31:0] W4   = 32'h00500713;
  localparam logic [31:0] W100 = 32'h0ff00793;
  localparam logic [31:0] W200 = 32'h12345678;

  logic [7:0] mem [0:1023];

  logic        stall8, br8, rdy8, ce8, v8;
  logic [31:0] ba8, addr8, inst8, pc8;
  logic [7:0]  rdata8;
  logic        stall16, br16, rdy16, ce16, v16;
  logic [31:0] ba16, addr16, inst16, pc16;
  logic [15:0] rdata16;
  logic        stall32, br32, rdy32, ce32, v32;
  logic [31:0] ba32, addr32, inst32, pc32;
  logic [31:0] rdata32;

  assign rdata8  = mem[addr8[9:0]];
  assign rdata16 = {mem[addr16[9:0] + 10'd1], mem[addr16[9:0]]};
  assign rdata32 = {mem[addr32[9:0] + 10'd3], mem[addr32[9:0] + 10'd2],
                    mem[addr32[9:0] + 10'd1], mem[addr32[9:0]]};

  if_prefetch #(.MEM_W(8), .IQ_DEPTH(4), .RESET_PC(32'h0)) u8 (
    .clk(clk), .rst(rst), .stall_i(stall8), .branch_flag_i(br8),
    .branch_addr_i(ba8), .mem_ce_o(ce8), .mem_addr_o(addr8),
    .mem_ready_i(rdy8), .mem_rdata_i(rdata8), .if_valid_o(v8),
    .if_inst_o(inst8), .if_pc_o(pc8));

  if_prefetch #(.MEM_W(16), .IQ_DEPTH(4), .RESET_PC(32'h0)) u16 (
    .clk(clk), .rst(rst), .stall_i(stall16), .branch_flag_i(br16),
    .branch_addr_i(ba16), .mem_ce_o(ce16), .mem_addr_o(addr16),
    .mem_ready_i(rdy16), .mem_rdata_i(rdata16), .if_valid_o(v16),
    .if_inst_o(inst16), .if_pc_o(pc16));

  if_prefetch #(.MEM_W(32), .IQ_DEPTH(4), .RESET_PC(32'h0)) u32 (
    .clk(clk), .rst(rst), .stall_i(stall32), .branch_flag_i(br32),
    .branch_addr_i(ba32), .mem_ce_o(ce32), .mem_addr_o(addr32),
    .mem_ready_i(rdy32), .mem_rdata_i(rdata32), .if_valid_o(v32),
    .if_inst_o(inst32), .if_pc_o(pc32));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic put_word(input int a, input logic [31:0] w);
    mem[a]   = w[7:0];
    mem[a+1] = w[15:8];
    mem[a+2] = w[23:16];
    mem[a+3] = w[31:24];
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the caller at the negedge of cycle 0 (first cycle with rst low).
  task automatic do_reset();
    stall8 = 1; br8 = 0; rdy8 = 0; ba8 = 0;
    stall16 = 1; br16 = 0; rdy16 = 0; ba16 = 0;
    stall32 = 1; br32 = 0; rdy32 = 0; ba32 = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic wait_valid8(output int waited);
    waited = 0;
    while (!v8 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
  endtask

  typedef struct {
    logic        stall;
    logic        ready;
    logic        exp_ce;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int waited;
    logic [31:0] addrs [$];
    logic [31:0] exp_pcs [5];
    logic [31:0] exp_ins [5];
    logic [31:0] resume_addr;

    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    put_word(32'h000, W0);
    put_word(32'h004, W1);
    put_word(32'h008, W2);
    put_word(32'h00C, W3);
    put_word(32'h010, W4);
    put_word(32'h100, W100);
    put_word(32'h200, W200);

    //           stall ready  ce    addr   valid inst  pc
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'h1, 1'b0, 32'h0, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'h2, 1'b0, 32'h0, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'h3, 1'b0, 32'h0, 32'h0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h4, 1'b1, W0,    32'h0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 32'h5, 1'b1, W0,    32'h0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'h6, 1'b1, W0,    32'h0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 32'h7, 1'b0, 32'h0, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'h8, 1'b1, W1,    32'h4};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 32'h8, 1'b1, W1,    32'h4};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 32'h9, 1'b1, W1,    32'h4};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 32'hA, 1'b1, W1,    32'h4};

    // Byte-wide streaming from reset, with one pop and one ready gap.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      stall8 = tbl[i].stall;
      rdy8   = tbl[i].ready;
      check($sformatf("tbl%0d_ce", i),    {31'b0, ce8}, {31'b0, tbl[i].exp_ce});
      check($sformatf("tbl%0d_addr", i),  addr8,        tbl[i].exp_addr);
      check($sformatf("tbl%0d_valid", i), {31'b0, v8},  {31'b0, tbl[i].exp_valid});
      check($sformatf("tbl%0d_inst", i),  inst8,        tbl[i].exp_inst);
      check($sformatf("tbl%0d_pc", i),    pc8,          tbl[i].exp_pc);
      $display("tbl row %0d: ce=%0b addr=%h valid=%0b inst=%h pc=%h", i, ce8, addr8, v8, inst8, pc8);
      tick(1);
    end

    // 16-bit port, ready toggling: address holds, halves land in order.
    do_reset();
    rdy16 = 1;
    tick(1);
    check("w16_c1_addr", addr16, 32'h0);
    check("w16_c1_ce", {31'b0, ce16}, 32'd1);
    tick(1);
    rdy16 = 0;
    check("w16_c2_addr", addr16, 32'h2);
    tick(1);
    rdy16 = 1;
    check("w16_c3_addr_held", addr16, 32'h2);
    check("w16_c3_valid", {31'b0, v16}, 32'd0);
    tick(1);
    rdy16 = 0;
    check("w16_c4_addr", addr16, 32'h4);
    check("w16_c4_valid", {31'b0, v16}, 32'd1);
    check("w16_c4_inst", inst16, W0);
    check("w16_c4_pc", pc16, 32'h0);
    $display("w16 word: valid=%0b inst=%h pc=%h", v16, inst16, pc16);

    // 32-bit port stalled: fills exactly four words then stops requesting.
    do_reset();
    rdy32 = 1;
    for (int c = 0; c < 16; c++) begin
      if (ce32) addrs.push_back(addr32);
      tick(1);
    end
    check("w32_fetch_count", addrs.size(), 32'd4);
    for (int k = 0; k < 4 && k < addrs.size(); k++)
      check($sformatf("w32_fetch_addr%0d", k), addrs[k], 32'(k * 4));
    check("w32_full_ce", {31'b0, ce32}, 32'd0);
    check("w32_full_valid", {31'b0, v32}, 32'd1);
    exp_pcs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    exp_ins = '{W0, W1, W2, W3, W4};
    resume_addr = 32'hFFFF_FFFF;
    stall32 = 0;
    for (int k = 0; k < 5; k++) begin
      if (ce32 && resume_addr == 32'hFFFF_FFFF) resume_addr = addr32;
      check($sformatf("w32_pop%0d_valid", k), {31'b0, v32}, 32'd1);
      check($sformatf("w32_pop%0d_pc", k), pc32, exp_pcs[k]);
      check($sformatf("w32_pop%0d_inst", k), inst32, exp_ins[k]);
      $display("w32 pop %0d: pc=%h inst=%h", k, pc32, inst32);
      tick(1);
    end
    check("w32_resume_addr", resume_addr, 32'h10);
    stall32 = 1;
    rdy32 = 0;

    // Branch with two words queued and the assembler at beat 2.
    do_reset();
    rdy8 = 1;
    tick(11);
    check("br_pre_addr", addr8, 32'hA);
    check("br_pre_pc", pc8, 32'h0);
    br8 = 1;
    ba8 = 32'h102;
    tick(1);
    br8 = 0;
    check("br_valid_after", {31'b0, v8}, 32'd0);
    check("br_ce_after", {31'b0, ce8}, 32'd1);
    check("br_addr_after", addr8, 32'h100);
    wait_valid8(waited);
    check("br_valid", {31'b0, v8}, 32'd1);
    check("br_latency", waited, 32'd4);
    check("br_first_pc", pc8, 32'h100);
    check("br_first_inst", inst8, W100);
    $display("branch target: pc=%h inst=%h after %0d cycles", pc8, inst8, waited);

    // Branch coincident with a last-beat push and a pop.
    do_reset();
    rdy8 = 1;
    tick(8);
    check("brc_pre_addr", addr8, 32'h7);
    check("brc_pre_valid", {31'b0, v8}, 32'd1);
    stall8 = 0;
    br8 = 1;
    ba8 = 32'h200;
    tick(1);
    br8 = 0;
    stall8 = 1;
    check("brc_valid_after", {31'b0, v8}, 32'd0);
    check("brc_addr_after", addr8, 32'h200);
    wait_valid8(waited);
    check("brc_valid", {31'b0, v8}, 32'd1);
    check("brc_first_pc", pc8, 32'h200);
    check("brc_first_inst", inst8, W200);
    $display("coincident branch: pc=%h inst=%h", pc8, inst8);

    // Fill to full, pop once, then reset partway through a word.
    do_reset();
    rdy8 = 1;
    tick(16);
    check("full_c16_ce", {31'b0, ce8}, 32'd1);
    check("full_c16_addr", addr8, 32'hF);
    tick(1);
    check("full_c17_ce", {31'b0, ce8}, 32'd0);
    stall8 = 0;
    tick(1);
    stall8 = 1;
    check("full_resume_ce", {31'b0, ce8}, 32'd1);
    check("full_resume_addr", addr8, 32'h10);
    check("full_resume_pc", pc8, 32'h4);
    tick(2);
    rst = 1;
    tick(1);
    check("rst_ce", {31'b0, ce8}, 32'd0);
    check("rst_addr", addr8, 32'h0);
    check("rst_valid", {31'b0, v8}, 32'd0);
    check("rst_inst", inst8, 32'h0);
    check("rst_pc", pc8, 32'h0);
    rst = 0;
    tick(1);
    check("rst_restart_ce", {31'b0, ce8}, 32'd1);
    check("rst_restart_addr", addr8, 32'h0);
    wait_valid8(waited);
    check("rst_restart_valid", {31'b0, v8}, 32'd1);
    check("rst_restart_pc", pc8, 32'h0);
    check("rst_restart_inst", inst8, W0);
    $display("after reset: pc=%h inst=%h", pc8, inst8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
